// File: rtl/snake_tile_renderer.sv
// rtl/snake_tile_renderer.sv - 40x30 tile map with 2-cycle pixel colour pipeline and clear sweep (optional border: SNAKE_BORDER_EN)
module snake_tile_renderer #(
  parameter logic [7:0] COL_BG     = 8'h00,
  parameter logic [7:0] COL_BODY   = 8'h1C,
  parameter logic [7:0] COL_HEAD   = 8'hFC,
  parameter logic [7:0] COL_TARGET = 8'hE0,
  parameter logic [7:0] COL_BORDER = 8'h03
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] ADDRH,
  input  logic [8:0] ADDRV,
  output logic [7:0] COLOUR_OUT,
  input  logic       WR_EN,
  input  logic [5:0] WR_X,
  input  logic [4:0] WR_Y,
  input  logic [1:0] WR_TILE,
  output logic       WR_READY,
  input  logic       CLEAR_REQ,
  output logic       CLEAR_BUSY
);

  localparam int          MAP_W    = 40;
  localparam int          MAP_H    = 30;
  localparam int          MAP_N    = MAP_W * MAP_H;
  localparam logic [10:0] LAST_IDX = 11'(MAP_N - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  logic [1:0]  map_mem [0:MAP_N-1];

  state_t      state_q, state_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;

  logic        mem_we;
  logic [10:0] mem_waddr;
  logic [1:0]  mem_wdata;

  logic [5:0]  rd_col;
  logic [4:0]  rd_row;
  logic        rd_vis;
  logic [10:0] rd_idx;

  logic        wr_in_range;
  logic [10:0] wr_idx;

  logic [1:0]  code_q;
  logic        vis_q;
  logic [7:0]  pix_col;

  // Pixel address decode; off-screen addresses read entry 0 and are masked later
  always_comb begin
    rd_col = ADDRH[9:4];
    rd_row = ADDRV[8:4];
    rd_vis = (ADDRH < 10'd640) && (ADDRV < 9'd480);
    rd_idx = rd_vis ? (({6'd0, rd_row} * 11'd40) + {5'd0, rd_col}) : 11'd0;
  end

  // Write address decode; out-of-range tiles must never alias onto valid entries
  always_comb begin
    wr_in_range = (WR_X < 6'd40) && (WR_Y < 5'd30);
    wr_idx      = wr_in_range ? (({6'd0, WR_Y} * 11'd40) + {5'd0, WR_X}) : 11'd0;
  end

  // FSM state and clear counter registers; reset lands in CLEAR so the map is swept on release
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= 11'd0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state and single write-port arbitration: clear sweep, else an accepted tile write
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    mem_wdata = WR_TILE;
    case (state_q)
      S_IDLE: begin
        if (CLEAR_REQ) begin
          state_d   = S_CLEAR;
          clr_cnt_d = 11'd0;
        end else if (WR_EN && wr_in_range) begin
          mem_we = 1'b1;
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = 2'd0;
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = S_IDLE;
          clr_cnt_d = 11'd0;
        end else begin
          clr_cnt_d = clr_cnt_q + 11'd1;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_cnt_d = 11'd0;
      end
    endcase
  end

  assign WR_READY   = (state_q == S_IDLE);
  assign CLEAR_BUSY = (state_q == S_CLEAR);

  // Map storage; writes are suppressed while reset is held so the sweep alone defines contents
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) begin
      map_mem[mem_waddr] <= mem_wdata;
    end
  end

`ifdef SNAKE_BORDER_EN
  logic border_q;

  // Border flag travels alongside the map read so latency stays at two cycles
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      border_q <= 1'b0;
    end else begin
      border_q <= rd_vis && ((rd_col == 6'd0) || (rd_col == 6'd39) ||
                             (rd_row == 5'd0) || (rd_row == 5'd29));
    end
  end
`endif

  // Stage 1: synchronous map read (old value wins against a same-edge write)
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      code_q <= 2'd0;
      vis_q  <= 1'b0;
    end else begin
      code_q <= map_mem[rd_idx];
      vis_q  <= rd_vis;
    end
  end

  // Tile code to RGB332, with blanking and optional border override
  always_comb begin
    case (code_q)
      2'd1:    pix_col = COL_BODY;
      2'd2:    pix_col = COL_HEAD;
      2'd3:    pix_col = COL_TARGET;
      default: pix_col = COL_BG;
    endcase
    if (!vis_q) begin
      pix_col = COL_BG;
    end
`ifdef SNAKE_BORDER_EN
    else if (border_q) begin
      pix_col = COL_BORDER;
    end
`endif
  end

  // Stage 2: registered colour output
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      COLOUR_OUT <= 8'h00;
    end else begin
      COLOUR_OUT <= pix_col;
    end
  end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// tb/tb_snake_tile_renderer.sv - randomized model-checked bench for snake_tile_renderer
module tb_snake_tile_renderer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] ADDRH = '0;
  logic [8:0] ADDRV = '0;
  logic [7:0] COLOUR_OUT;
  logic       WR_EN = 1'b0;
  logic [5:0] WR_X = '0;
  logic [4:0] WR_Y = '0;
  logic [1:0] WR_TILE = '0;
  logic       WR_READY;
  logic       CLEAR_REQ = 1'b0;
  logic       CLEAR_BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  snake_tile_renderer dut (
    .CLK(CLK), .RESET(RESET), .ADDRH(ADDRH), .ADDRV(ADDRV), .COLOUR_OUT(COLOUR_OUT),
    .WR_EN(WR_EN), .WR_X(WR_X), .WR_Y(WR_Y), .WR_TILE(WR_TILE), .WR_READY(WR_READY),
    .CLEAR_REQ(CLEAR_REQ), .CLEAR_BUSY(CLEAR_BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference model: tile map (-1 = unknown), clear progress, two-deep colour delay line
  int m_map [1200];
  int m_busy = 1;
  int m_k = 0;
  int m_s1 = 0;
  int m_out = 0;

  initial for (int i = 0; i < 1200; i++) m_map[i] = -1;

  function automatic int colour_of(int h, int v);
    int code;
    if (h >= 640 || v >= 480) return 0;
`ifdef SNAKE_BORDER_EN
    if (h / 16 == 0 || h / 16 == 39 || v / 16 == 0 || v / 16 == 29) return 'h03;
`endif
    code = m_map[(v / 16) * 40 + (h / 16)];
    case (code)
      0: return 'h00;
      1: return 'h1C;
      2: return 'h FC;
      3: return 'hE0;
      default: return -1;
    endcase
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_busy = 1; m_k = 0; m_s1 = 0; m_out = 0;
    end else begin
      m_out = m_s1;
      m_s1  = colour_of(int'(ADDRH), int'(ADDRV));
      if (m_busy != 0) begin
        m_map[m_k] = 0;
        if (m_k == 1199) m_busy = 0;
        else m_k = m_k + 1;
      end else if (CLEAR_REQ) begin
        m_busy = 1; m_k = 0;
      end else if (WR_EN && WR_X < 40 && WR_Y < 30) begin
        m_map[int'(WR_Y) * 40 + int'(WR_X)] = int'(WR_TILE);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, away from the active edge
  always @(negedge CLK) begin
    n_cmp++;
    if (CLEAR_BUSY !== (m_busy != 0)) begin
      n_bad++;
      $display("FAIL busy t=%0t got=%b want=%0d", $time, CLEAR_BUSY, m_busy);
    end
    n_cmp++;
    if (WR_READY !== (m_busy == 0)) begin
      n_bad++;
      $display("FAIL ready t=%0t got=%b want=%0d", $time, WR_READY, (m_busy == 0));
    end
    if (m_out >= 0) begin
      n_cmp++;
      if (COLOUR_OUT !== 8'(m_out)) begin
        n_bad++;
        $display("FAIL colour t=%0t got=%h want=%h", $time, COLOUR_OUT, 8'(m_out));
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_write(input int x, input int y, input int t);
    @(negedge CLK);
    WR_EN = 1'b1; WR_X = x[5:0]; WR_Y = y[4:0]; WR_TILE = t[1:0];
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic pix_check(input string name, input int h, input int v, input int want);
    @(negedge CLK);
    ADDRH = h[9:0]; ADDRV = v[8:0];
    @(negedge CLK);
    @(negedge CLK);
    check(name, int'(COLOUR_OUT), want);
  endtask

  // Called on a negedge; counts consecutive busy samples, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (CLEAR_BUSY && n < 3000) begin
      n++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int n;
    repeat (4) @(negedge CLK);
    check("reset_colour", int'(COLOUR_OUT), 0);
    check("reset_busy", int'(CLEAR_BUSY), 1);
    check("reset_ready", int'(WR_READY), 0);

    RESET = 1'b0;
    count_busy(n);
    check("initial_sweep_len", n, 1200);
    check("ready_after_sweep", int'(WR_READY), 1);

    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      ADDRH = 10'($urandom_range(0, 639)); ADDRV = 9'($urandom_range(0, 479));
    end

    do_write(5, 3, 2);
    pix_check("head_pixel", 85, 55, 'hFC);
    pix_check("neighbour_pixel", 96, 55, 'h00);

    do_write(40, 0, 1);
`ifndef SNAKE_BORDER_EN
    pix_check("oob_write_px00", 0, 0, 'h00);
    pix_check("oob_write_tile40", 0, 16, 'h00);
`else
    do_write(0, 0, 3);
    pix_check("border_px33", 3, 3, 'h03);
    do_write(1, 1, 1);
    pix_check("inner_px16", 16, 16, 'h1C);
`endif

    @(negedge CLK);
    CLEAR_REQ = 1'b1; WR_EN = 1'b1; WR_X = 6'd7; WR_Y = 5'd7; WR_TILE = 2'd3;
    @(negedge CLK);
    CLEAR_REQ = 1'b0; WR_EN = 1'b0;
    n = 0;
    while (CLEAR_BUSY && n < 3000) begin
      n++;
      CLEAR_REQ = (n == 600);
      @(negedge CLK);
    end
    CLEAR_REQ = 1'b0;
    check("clear_sweep_len", n, 1200);
    pix_check("dropped_write", 112, 112, 'h00);

    do_write(10, 10, 1);
    do_write(11, 10, 3);
    @(negedge CLK);
    CLEAR_REQ = 1'b1;
    @(negedge CLK);
    CLEAR_REQ = 1'b0;
    repeat (600) begin
      @(negedge CLK);
      ADDRH = 10'($urandom_range(150, 200)); ADDRV = 9'($urandom_range(150, 180));
    end
    #1 RESET = 1'b1;
    @(negedge CLK);
    check("midsweep_reset_colour", int'(COLOUR_OUT), 0);
    RESET = 1'b0;
    count_busy(n);
    check("restarted_sweep_len", n, 1200);

    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      ADDRH = 10'($urandom_range(0, 799));
      ADDRV = 9'($urandom_range(0, 524));
      WR_EN = ($urandom_range(0, 2) == 0);
      WR_X = 6'($urandom_range(0, 45));
      WR_Y = 5'($urandom_range(0, 31));
      WR_TILE = 2'($urandom);
      CLEAR_REQ = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 1999) == 0) begin
        #1 RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
      end
    end
    @(negedge CLK);
    WR_EN = 1'b0; CLEAR_REQ = 1'b0;
    repeat (3) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_tile_renderer.md
SNAKE_TILE_RENDERER -- requirements
Module: snake_tile_renderer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- COL_BG, 8'h00, empty-tile colour (RGB332)
- COL_BODY, 8'h1C, snake-body colour
- COL_HEAD, 8'hFC, snake-head colour
- COL_TARGET, 8'hE0, target colour
- COL_BORDER, 8'h03, border colour (used only with SNAKE_BORDER_EN)
REQ-002 Ports, one per line (name, direction, width, meaning):
- CLK, in, 1, pixel clock, same clock as the VGA timing stage
- RESET, in, 1, asynchronous, active-high
- ADDRH, in, 10, pixel column from the VGA timing stage; 0..639 is visible
- ADDRV, in, 9, pixel row from the VGA timing stage; 0..479 is visible
- COLOUR_OUT, out, 8, pixel colour fed to the VGA timing stage colour input
- WR_EN, in, 1, tile write request
- WR_X, in, 6, tile column, 0..39
- WR_Y, in, 5, tile row, 0..29
- WR_TILE, in, 2, tile code: 0 empty, 1 body, 2 head, 3 target
- WR_READY, out, 1, write port accepts WR_EN this cycle
- CLEAR_REQ, in, 1, request to clear the whole map to empty
- CLEAR_BUSY, out, 1, clear sweep in progress
REQ-003 There is one clock, CLK; RESET is asynchronous and active-high.

Function
REQ-004 Map: 40x30 tiles of 2 bits each (1200 entries); each tile is 16x16 pixels; linear index = Y*40 + X.
REQ-005 Read pipeline:
- Tile column = ADDRH[9:4]; tile row = ADDRV[8:4].
- The map is read synchronously on the first rising edge after the address is sampled.
- COLOUR_OUT is registered on the second edge after sampling; fixed latency is 2 cycles.
- There are no bubbles; a new pixel is accepted every cycle.
REQ-006 Colour map:
- Code 0 gives COL_BG, 1 gives COL_BODY, 2 gives COL_HEAD, 3 gives COL_TARGET.
- ADDRH>=640 or ADDRV>=480 gives COL_BG.
REQ-007 Write port:
- WR_READY=1 only in state IDLE.
- A write is accepted when WR_EN && WR_READY.
- An accepted write updates the map on that rising edge.
- WR_EN while WR_READY=0 is dropped; no queueing.
REQ-008 Writes with WR_X>=40 or WR_Y>=30 are ignored, with no aliasing.
REQ-009 A pixel read of the tile being written in the same cycle returns the old value (read-before-write).
REQ-010 FSM states are IDLE and CLEAR.
- IDLE to CLEAR: on CLEAR_REQ=1; the clear counter is loaded with 0.
- CLEAR: writes code 0 at the counter address, one entry per cycle, incrementing 0..1199.
- CLEAR to IDLE: after writing index 1199. The sweep takes exactly 1200 cycles.
- CLEAR_BUSY=1 exactly while in CLEAR.
REQ-011 CLEAR_REQ while in CLEAR is ignored; the sweep does not restart.
REQ-012 CLEAR_REQ and WR_EN in the same IDLE cycle: the clear wins, the write is dropped, and the FSM enters CLEAR.
REQ-013 The read pipeline keeps running during CLEAR; pixels show a mix of old and cleared tiles.

Reset
REQ-014 While RESET=1:
- COLOUR_OUT=8'h00 and the pipeline registers are 0.
- The FSM is in CLEAR with the clear counter at 0.
- CLEAR_BUSY=1 and WR_READY=0.
REQ-015 After RESET deasserts, the automatic 1200-cycle clear runs, so the map is all empty before the first write is accepted.
REQ-016 Asserting RESET mid-sweep or mid-write restarts the clear from index 0; no partial state survives.

Configuration
REQ-017 Macro SNAKE_BORDER_EN:
- Defined: tiles with column 0, column 39, row 0 or row 29 show COL_BORDER, overriding map contents. Writes to those tiles are still stored. Latency is unchanged.
- Undefined: no border logic; the COL_BORDER parameter is unused.

Verification
REQ-018 Reset then release:
- CLEAR_BUSY=1 for exactly 1200 cycles, then WR_READY=1.
- COLOUR_OUT=8'h00 for all visible pixels, with the macro undefined.
REQ-019 Write (X=5,Y=3,TILE=2) then drive ADDRH=85, ADDRV=55 -> COLOUR_OUT=8'hFC two cycles later. ADDRH=96 in the same row -> 8'h00.
REQ-020 Write X=40,Y=0,TILE=1 -> ignored. Pixel (0,0) stays 8'h00, and tile (0,1), index 40, is unchanged.
REQ-021 Assert CLEAR_REQ and WR_EN in the same cycle -> write dropped, CLEAR_BUSY high for 1200 cycles. A re-pulse of CLEAR_REQ mid-sweep does not extend the sweep.
REQ-022 Pulse RESET at sweep index 600 -> sweep restarts at 0 and completes 1200 cycles after release.
REQ-023 With SNAKE_BORDER_EN defined, write (0,0,TILE=3) -> pixel (3,3) shows 8'h03, and pixel (16,16) shows the map colour.
